j_addr_bus_driver: RTL and testbench
====================================

// Module: j_addr_bus_driver
//
// PURPOSE
// - Source side of the J register pair: holds J1 (high byte) and J2 (low byte) loaded from the 8-bit data bus.
// - On request, drives the 16-bit J value onto the address bus (selJ), for GOTO/CALL jumps into PC.
// - Models relay make/break timing with a settle phase, a drive phase and a release phase.
// - Handshakes with the sequencer via a level request / level acknowledge pair.
//
// PARAMETERS
// - ADDR_W      16  address bus width; J1 = ADDR_W/2 MSBs, J2 = ADDR_W/2 LSBs
// - SETTLE_CYC  2   cycles between bus enable and ack (relay make time); 0 allowed
// - RELEASE_CYC 1   cycles bus held off after req drops before new req accepted; >=1
//
// PORTS
// - clk          in   1         system clock, rising edge
// - rst_n        in   1         asynchronous reset, active-low
// - data_in      in   ADDR_W/2  data bus value
// - ld_j1        in   1         load J1 from data_in this edge
// - ld_j2        in   1         load J2 from data_in this edge
// - sel_j_req    in   1         level request to drive J onto address bus
// - sel_j_ack    out  1         J valid and stable on address bus
// - addr_out     out  ADDR_W    address bus drive value; all-zero when addr_oe=0
// - addr_oe      out  1         address bus output enable
// - led_sel_j    out  1         panel LED; equals addr_oe
// - j_value      out  ADDR_W    {J1,J2}, always visible
// - err_contend  out  1         sticky load-while-driving flag (see CONFIGURATION)
//
// BEHAVIOUR
// - One clock, rst_n asynchronous active-low. Reset: J1=J2=0, state IDLE, all outputs 0.
// - Loads: ld_j1/ld_j2 capture data_in on rising edge, only in IDLE; both high -> both load same value.
// - Loads in any non-IDLE state are ignored; J frozen while bus may be driven.
// - FSM states IDLE, SETTLE, DRIVE, RELEASE; counter width clog2(max(SETTLE_CYC,RELEASE_CYC)+1).
// - IDLE: req=1 -> SETTLE (counter=0), or DRIVE directly if SETTLE_CYC=0.
// - SETTLE: addr_oe=1, addr_out=J, ack=0; counter reaches SETTLE_CYC-1 -> DRIVE; req=0 -> RELEASE (abort).
// - DRIVE: addr_oe=1, ack=1, addr_out=J; stays while req=1; req=0 -> RELEASE.
// - RELEASE: addr_oe=0, ack=0, addr_out=0; after RELEASE_CYC cycles -> IDLE; req ignored meanwhile.
// - Latency: req sampled high at edge k -> oe high after edge k, ack high after edge k+SETTLE_CYC.
// - ack deasserts in the cycle after req sampled low; outputs registered, no comb path req->ack.
// - Req held high through RELEASE -> new transaction starts from IDLE on following edge.
// - Reset mid-operation: immediate drop of oe/ack/led, J cleared, state IDLE.
//
// CONFIGURATION
// - Macro J_CONTEND_CHECK_EN.
// - Defined: ld_j1|ld_j2 sampled in non-IDLE state sets err_contend=1; cleared only by rst_n.
// - Undefined: err_contend tied 0; logic absent. Load-ignore behaviour identical either way.
//
// STRUCTURE
// - Shared package relay_pkg: typedef enum j_drv_state_t {IDLE,SETTLE,DRIVE,RELEASE}; ADDR_W default constant.
// - Sub-module relay_delay_cnt (load/count/done) reused for settle and release phases.
// - J register pair inline; no other hierarchy.
//
// TESTING
// - Reset: assert rst_n=0 mid-DRIVE -> oe, ack, led, j_value all 0 same cycle (async).
// - Load: data_in=8'hA5 ld_j1, then 8'h3C ld_j2 -> j_value=16'hA53C; ld both with 8'h7E -> 16'h7E7E.
// - Drive: J=16'h1234, req held -> oe rises 1 cycle, ack after 2 more, addr_out=16'h1234 while req.
// - Abort: req drops during SETTLE -> never ack, oe low next cycle, IDLE after RELEASE_CYC.
// - Back-to-back: req held through RELEASE -> exactly RELEASE_CYC cycles oe=0 before next SETTLE.
// - Contention (J_CONTEND_CHECK_EN): ld_j2=1 with data_in=8'hFF during DRIVE -> j_value unchanged, err_contend=1 sticky.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types for the relay-timed J address bus driver.
package relay_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DRIVE,
    RELEASE
  } j_drv_state_t;

endpackage

// File: rtl/relay_delay_cnt.sv
// Small up-counter timing the relay settle and release phases.
module relay_delay_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         done
);

  logic [W-1:0] cnt;

  // load restarts the phase at zero; done flags the last cycle of the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == target);

endmodule

// File: rtl/j_addr_bus_driver.sv
// J register pair and relay-timed address bus driver with level req/ack handshake.
// Optional load-while-driving detection is enabled by defining J_CONTEND_CHECK_EN.
module j_addr_bus_driver
  import relay_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SETTLE_CYC  = 2,
  parameter int RELEASE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W/2-1:0] data_in,
  input  logic              ld_j1,
  input  logic              ld_j2,
  input  logic              sel_j_req,
  output logic              sel_j_ack,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  output logic              led_sel_j,
  output logic [ADDR_W-1:0] j_value,
  output logic              err_contend
);

  localparam int HALF_W  = ADDR_W / 2;
  localparam int MAX_CYC = (SETTLE_CYC > RELEASE_CYC) ? SETTLE_CYC : RELEASE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);

  // With no relay make time a request goes straight to DRIVE with ack
  localparam j_drv_state_t START_STATE = (SETTLE_CYC == 0) ? DRIVE : SETTLE;
  localparam logic         START_ACK   = (SETTLE_CYC == 0);

  j_drv_state_t      state;
  logic [HALF_W-1:0] j1;
  logic [HALF_W-1:0] j2;
  logic [HALF_W-1:0] j1_next;
  logic [HALF_W-1:0] j2_next;
  logic              in_idle;
  logic              cnt_load;
  logic              cnt_done;
  logic [CNT_W-1:0]  cnt_target;

  assign in_idle = (state == IDLE);
  assign j1_next = (in_idle && ld_j1) ? data_in : j1;
  assign j2_next = (in_idle && ld_j2) ? data_in : j2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j1 <= '0;
      j2 <= '0;
    end else begin
      j1 <= j1_next;
      j2 <= j2_next;
    end
  end

  assign j_value = {j1, j2};

  // Counter sits at zero outside the timed phases and restarts on every phase exit
  assign cnt_load = (state == IDLE) || (state == DRIVE) ||
                    ((state == SETTLE) && (!sel_j_req || cnt_done)) ||
                    ((state == RELEASE) && cnt_done);
  assign cnt_target = (state == RELEASE) ? RELEASE_LAST : SETTLE_LAST;

  relay_delay_cnt #(
    .W(CNT_W)
  ) u_delay_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .en     (1'b1),
    .target (cnt_target),
    .done   (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_oe   <= 1'b0;
      sel_j_ack <= 1'b0;
      addr_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_j_req) begin
            state     <= START_STATE;
            addr_oe   <= 1'b1;
            sel_j_ack <= START_ACK;
            addr_out  <= {j1_next, j2_next};
          end
        end
        SETTLE: begin
          if (!sel_j_req) begin
            state     <= RELEASE;
            addr_oe   <= 1'b0;
            sel_j_ack <= 1'b0;
            addr_out  <= '0;
          end else if (cnt_done) begin
            state     <= DRIVE;
            sel_j_ack <= 1'b1;
          end
        end
        DRIVE: begin
          if (!sel_j_req) begin
            state     <= RELEASE;
            addr_oe   <= 1'b0;
            sel_j_ack <= 1'b0;
            addr_out  <= '0;
          end
        end
        RELEASE: begin
          // A request still pending when the bus has been off long enough restarts at once
          if (cnt_done) begin
            if (sel_j_req) begin
              state     <= START_STATE;
              addr_oe   <= 1'b1;
              sel_j_ack <= START_ACK;
              addr_out  <= j_value;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          addr_oe   <= 1'b0;
          sel_j_ack <= 1'b0;
          addr_out  <= '0;
        end
      endcase
    end
  end

  assign led_sel_j = addr_oe;

`ifdef J_CONTEND_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_contend <= 1'b0;
    end else if ((ld_j1 || ld_j2) && !in_idle) begin
      err_contend <= 1'b1;
    end
  end
`else
  assign err_contend = 1'b0;
`endif

endmodule

// File: tb/tb_j_addr_bus_driver.sv
// Directed self-checking bench for j_addr_bus_driver (default SETTLE_CYC=2, RELEASE_CYC=1).
module tb_j_addr_bus_driver;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        ld_j1;
  logic        ld_j2;
  logic        sel_j_req;
  logic        sel_j_ack;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic        led_sel_j;
  logic [15:0] j_value;
  logic        err_contend;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef J_CONTEND_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  j_addr_bus_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .ld_j1       (ld_j1),
    .ld_j2       (ld_j2),
    .sel_j_req   (sel_j_req),
    .sel_j_ack   (sel_j_ack),
    .addr_out    (addr_out),
    .addr_oe     (addr_oe),
    .led_sel_j   (led_sel_j),
    .j_value     (j_value),
    .err_contend (err_contend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic l1, input logic l2, input logic req);
    data_in   = d;
    ld_j1     = l1;
    ld_j2     = l2;
    sel_j_req = req;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_oe", 32'(addr_oe), 32'd0);
    checkOutput("rst_ack", 32'(sel_j_ack), 32'd0);
    checkOutput("rst_addr", 32'(addr_out), 32'd0);
    checkOutput("rst_led", 32'(led_sel_j), 32'd0);
    checkOutput("rst_j", 32'(j_value), 32'd0);
    checkOutput("rst_err", 32'(err_contend), 32'd0);
    rst_n = 1'b1;
    tick();

    // Loads
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0); tick();
    checkOutput("load_j1", 32'(j_value), 32'hA500);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("load_j2", 32'(j_value), 32'hA53C);
    applyStimulus(8'h7E, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("load_both", 32'(j_value), 32'h7E7E);
    applyStimulus(8'h12, 1'b1, 1'b0, 1'b0); tick();
    applyStimulus(8'h34, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("load_1234", 32'(j_value), 32'h1234);

    // Drive: oe one edge after req, ack two edges later
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("drv_oe_k", 32'(addr_oe), 32'd1);
    checkOutput("drv_led_k", 32'(led_sel_j), 32'd1);
    checkOutput("drv_ack_k", 32'(sel_j_ack), 32'd0);
    checkOutput("drv_addr_k", 32'(addr_out), 32'h1234);
    tick();
    checkOutput("drv_ack_k1", 32'(sel_j_ack), 32'd0);
    checkOutput("drv_oe_k1", 32'(addr_oe), 32'd1);
    tick();
    checkOutput("drv_ack_k2", 32'(sel_j_ack), 32'd1);
    checkOutput("drv_addr_k2", 32'(addr_out), 32'h1234);
    tick();
    checkOutput("drv_ack_hold", 32'(sel_j_ack), 32'd1);

    // Load during DRIVE is ignored; contention flag is sticky when enabled
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("cont_j", 32'(j_value), 32'h1234);
    checkOutput("cont_addr", 32'(addr_out), 32'h1234);
    checkOutput("cont_err", 32'(err_contend), 32'(ERR_EXP));
    tick();
    checkOutput("cont_err_sticky", 32'(err_contend), 32'(ERR_EXP));

    // Release
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("rel_oe", 32'(addr_oe), 32'd0);
    checkOutput("rel_ack", 32'(sel_j_ack), 32'd0);
    checkOutput("rel_addr", 32'(addr_out), 32'd0);
    tick();

    // Abort during SETTLE, then prove IDLE by a load that must land
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("abort_oe_up", 32'(addr_oe), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("abort_oe_down", 32'(addr_oe), 32'd0);
    checkOutput("abort_ack", 32'(sel_j_ack), 32'd0);
    tick();
    checkOutput("abort_ack_late", 32'(sel_j_ack), 32'd0);
    applyStimulus(8'h56, 1'b1, 1'b0, 1'b0); tick();
    checkOutput("abort_idle_load", 32'(j_value), 32'h5634);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0); tick();

    // Back-to-back: exactly one oe-low cycle before the next SETTLE
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();
    checkOutput("b2b_ack1", 32'(sel_j_ack), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("b2b_gap_oe", 32'(addr_oe), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("b2b_restart_oe", 32'(addr_oe), 32'd1);
    checkOutput("b2b_restart_ack", 32'(sel_j_ack), 32'd0);
    checkOutput("b2b_restart_addr", 32'(addr_out), 32'h5634);
    tick();
    checkOutput("b2b_ack_wait", 32'(sel_j_ack), 32'd0);
    tick();
    checkOutput("b2b_ack2", 32'(sel_j_ack), 32'd1);

    // Asynchronous reset mid-DRIVE
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_oe", 32'(addr_oe), 32'd0);
    checkOutput("arst_ack", 32'(sel_j_ack), 32'd0);
    checkOutput("arst_led", 32'(led_sel_j), 32'd0);
    checkOutput("arst_j", 32'(j_value), 32'd0);
    checkOutput("arst_addr", 32'(addr_out), 32'd0);
    checkOutput("arst_err", 32'(err_contend), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_oe", 32'(addr_oe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
